// File: rtl/swap_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : swap_req_ctrl
// Purpose  : Queues swap requests and issues them as timed swap sequences,
//            alternating fairly with host register-file accesses.
//            Macro SWAP_REQ_CTRL_STATS_EN adds saturating swap/no-op counters.
// Revision : 1.0 - initial release
// ============================================================================
module swap_req_ctrl #(
    parameter int ADDR_WIDTH  = 7,
    parameter int DEPTH       = 4,
    parameter int SWAP_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr_a,
    input  logic [ADDR_WIDTH-1:0]   req_addr_b,
    input  logic                    host_req,
    output logic                    host_gnt,
    output logic                    swap,
    output logic [ADDR_WIDTH-1:0]   addr_A,
    output logic [ADDR_WIDTH-1:0]   addr_B,
    output logic                    busy,
    output logic                    done,
`ifdef SWAP_REQ_CTRL_STATS_EN
    output logic [15:0]             swap_count,
    output logic [15:0]             nop_count,
`endif
    output logic [$clog2(DEPTH):0]  pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(SWAP_CYCLES + 1);
    localparam logic [PTR_W:0]   FULL_LEVEL = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(SWAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_a_q, addr_a_d;
    logic [ADDR_WIDTH-1:0]  addr_b_q, addr_b_d;
    logic                   prio_host_q, prio_host_d;

    logic [ADDR_WIDTH-1:0]  fifo_a_mem [DEPTH];
    logic [ADDR_WIDTH-1:0]  fifo_b_mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]         level_q;

    logic                   fifo_empty, fifo_full, push, pop;
    logic [ADDR_WIDTH-1:0]  head_a, head_b;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == FULL_LEVEL);
    assign req_ready  = !fifo_full;
    assign push       = req_valid && !fifo_full;
    assign host_gnt   = (state_q == IDLE) && host_req && (fifo_empty || prio_host_q);
    assign pop        = (state_q == IDLE) && !fifo_empty && !host_gnt;
    assign head_a     = fifo_a_mem[rd_ptr_q];
    assign head_b     = fifo_b_mem[rd_ptr_q];
    assign pending    = level_q;

    // Storage is not reset; the level counter alone defines what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a_mem[wr_ptr_q] <= req_addr_a;
            fifo_b_mem[wr_ptr_q] <= req_addr_b;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            prio_host_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            prio_host_q <= prio_host_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        addr_a_d    = addr_a_q;
        addr_b_d    = addr_b_q;
        prio_host_d = prio_host_q;

        // pop and host_gnt are mutually exclusive, so the order here is moot.
        if (host_gnt) prio_host_d = 1'b0;
        if (pop)      prio_host_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (pop) begin
                    addr_a_d = head_a;
                    addr_b_d = head_b;
                    state_d  = (head_a != head_b) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                wait_cnt_d = WAIT_LOAD;
                state_d    = WAIT;
            end
            WAIT: begin
                if (wait_cnt_q == '0) state_d = DONE;
                else                  wait_cnt_d = wait_cnt_q - 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign swap   = (state_q == ISSUE);
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign addr_A = addr_a_q;
    assign addr_B = addr_b_q;

`ifdef SWAP_REQ_CTRL_STATS_EN
    logic [15:0] swap_count_q, nop_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            swap_count_q <= '0;
            nop_count_q  <= '0;
        end else begin
            if (state_q == ISSUE && swap_count_q != 16'hFFFF)
                swap_count_q <= swap_count_q + 1'b1;
            if (pop && head_a == head_b && nop_count_q != 16'hFFFF)
                nop_count_q <= nop_count_q + 1'b1;
        end
    end

    assign swap_count = swap_count_q;
    assign nop_count  = nop_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_swap_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_swap_req_ctrl
// Purpose  : Directed self-checking bench for swap_req_ctrl (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_swap_req_ctrl;

    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr_a;
    logic [AW-1:0] req_addr_b;
    logic          host_req;
    logic          host_gnt;
    logic          swap;
    logic [AW-1:0] addr_A;
    logic [AW-1:0] addr_B;
    logic          busy;
    logic          done;
    logic [2:0]    pending;
`ifdef SWAP_REQ_CTRL_STATS_EN
    logic [15:0]   swap_count;
    logic [15:0]   nop_count;
`endif

    swap_req_ctrl #(
        .ADDR_WIDTH  (AW),
        .DEPTH       (4),
        .SWAP_CYCLES (3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr_a (req_addr_a),
        .req_addr_b (req_addr_b),
        .host_req   (host_req),
        .host_gnt   (host_gnt),
        .swap       (swap),
        .addr_A     (addr_A),
        .addr_B     (addr_B),
        .busy       (busy),
        .done       (done),
`ifdef SWAP_REQ_CTRL_STATS_EN
        .swap_count (swap_count),
        .nop_count  (nop_count),
`endif
        .pending    (pending)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int done_seen = 0;
    int gnt_busy_viol = 0;
    logic [AW-1:0] swap_a_log [$];
    logic [AW-1:0] swap_b_log [$];

    // Observer on the inactive edge: done pulses, swap addresses, grant-while-busy.
    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
        if (host_gnt === 1'b1 && busy === 1'b1) gnt_busy_viol++;
        if (swap === 1'b1) begin
            swap_a_log.push_back(addr_A);
            swap_b_log.push_back(addr_B);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int d0;

        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_addr_a = '0;
        req_addr_b = '0;
        host_req   = 1'b0;
        tick();
        tick();

        // ---- reset state ----
        chk("rst_pending",   32'(pending),   0);
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_busy",      32'(busy),      0);
        chk("rst_swap",      32'(swap),      0);
        chk("rst_done",      32'(done),      0);
        chk("rst_addr_A",    32'(addr_A),    0);
        chk("rst_addr_B",    32'(addr_B),    0);
        host_req = 1'b1;
        #1;
        chk("rst_host_gnt",  32'(host_gnt),  1);
        host_req = 1'b0;
        #1;
        chk("rst_no_gnt",    32'(host_gnt),  0);
        reset_n = 1'b1;
        tick();

        // ---- single request a=5 b=9 ----
        req_valid = 1'b1; req_addr_a = 7'd5; req_addr_b = 7'd9;
        tick();
        req_valid = 1'b0;
        chk("s_pending1",  32'(pending), 1);
        chk("s_idle",      32'(busy),    0);
        tick();
        chk("s_swap",      32'(swap),    1);
        chk("s_addr_A",    32'(addr_A),  5);
        chk("s_addr_B",    32'(addr_B),  9);
        chk("s_busy_iss",  32'(busy),    1);
        chk("s_pending0",  32'(pending), 0);
        tick();
        chk("s_swap_1cyc", 32'(swap),    0);
        chk("s_busy_w1",   32'(busy),    1);
        tick();
        tick();
        chk("s_busy_w3",   32'(busy),    1);
        chk("s_nodone_w3", 32'(done),    0);
        tick();
        chk("s_done",      32'(done),    1);
        chk("s_busy_done", 32'(busy),    1);
        tick();
        chk("s_done_off",  32'(done),    0);
        chk("s_idle_end",  32'(busy),    0);
        chk("s_pulses",    32'(swap_a_log.size()), 1);

        // ---- no-op request a=b=12 ----
        req_valid = 1'b1; req_addr_a = 7'd12; req_addr_b = 7'd12;
        tick();
        req_valid = 1'b0;
        chk("n_pending1",  32'(pending), 1);
        tick();
        chk("n_done",      32'(done),    1);
        chk("n_no_swap",   32'(swap),    0);
        chk("n_addr_A",    32'(addr_A),  12);
        chk("n_addr_B",    32'(addr_B),  12);
        chk("n_pending0",  32'(pending), 0);
        tick();
        chk("n_done_off",  32'(done),    0);
        chk("n_idle",      32'(busy),    0);
        chk("n_pulses",    32'(swap_a_log.size()), 1);
`ifdef SWAP_REQ_CTRL_STATS_EN
        chk("n_nop_count",  32'(nop_count),  1);
        chk("n_swap_count", 32'(swap_count), 1);
`endif

        // ---- fill the FIFO: six requests, the last waits for a pop ----
        swap_a_log.delete();
        swap_b_log.delete();
        d0 = done_seen;
        for (int k = 0; k < 6; k++) begin
            req_valid  = 1'b1;
            req_addr_a = AW'(k + 1);
            req_addr_b = AW'(k + 'h21);
            if (k == 5) begin
                chk("f_full_ready",   32'(req_ready), 0);
                chk("f_full_pending", 32'(pending),   4);
            end
            guard = 0;
            while (!req_ready && guard < 50) begin
                tick();
                guard++;
            end
            chk($sformatf("f_push_wait%0d", k), 32'(guard < 50), 1);
            if (k == 5) chk("f_refill_pending", 32'(pending), 3);
            tick();
        end
        req_valid = 1'b0;
        guard = 0;
        while ((pending != 0 || busy) && guard < 200) begin
            tick();
            guard++;
        end
        chk("f_drain_wait", 32'(guard < 200), 1);
        chk("f_pulses",     32'(swap_a_log.size()), 6);
        chk("f_dones",      32'(done_seen - d0),    6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("f_order_a%0d", k), 32'(swap_a_log[k]), k + 1);
            chk($sformatf("f_order_b%0d", k), 32'(swap_b_log[k]), k + 'h21);
        end

        // ---- host contention with two queued requests ----
        req_valid = 1'b1; req_addr_a = 7'h30; req_addr_b = 7'h31;
        tick();
        host_req = 1'b1;
        req_addr_a = 7'h32; req_addr_b = 7'h33;
        #1;
        chk("h_gnt1",      32'(host_gnt), 1);
        chk("h_idle1",     32'(busy),     0);
        tick();
        req_valid = 1'b0;
        chk("h_nogn1",     32'(host_gnt), 0);
        chk("h_pending2",  32'(pending),  2);
        chk("h_noswap1",   32'(swap),     0);
        tick();
        chk("h_swap1",     32'(swap),     1);
        chk("h_addrA1",    32'(addr_A),   'h30);
        chk("h_addrB1",    32'(addr_B),   'h31);
        chk("h_gnt_iss",   32'(host_gnt), 0);
        tick(); tick(); tick(); tick();
        chk("h_done1",     32'(done),     1);
        chk("h_gnt_done",  32'(host_gnt), 0);
        tick();
        chk("h_idle2",     32'(busy),     0);
        chk("h_gnt2",      32'(host_gnt), 1);
        chk("h_pending1",  32'(pending),  1);
        tick();
        chk("h_nogn2",     32'(host_gnt), 0);
        chk("h_noswap2",   32'(swap),     0);
        tick();
        chk("h_swap2",     32'(swap),     1);
        chk("h_addrA2",    32'(addr_A),   'h32);
        chk("h_addrB2",    32'(addr_B),   'h33);
        tick(); tick(); tick(); tick(); tick();
        chk("h_idle3",     32'(busy),     0);
        chk("h_gnt3",      32'(host_gnt), 1);
        chk("h_pending0",  32'(pending),  0);
        host_req = 1'b0;
        chk("h_gnt_busy_never", 32'(gnt_busy_viol), 0);

        // ---- reset during WAIT with two entries queued ----
        req_valid = 1'b1; req_addr_a = 7'h01; req_addr_b = 7'h02;
        tick();
        req_addr_a = 7'h03; req_addr_b = 7'h04;
        tick();
        req_addr_a = 7'h05; req_addr_b = 7'h06;
        tick();
        req_valid = 1'b0;
        chk("r_pending2",  32'(pending), 2);
        chk("r_busy",      32'(busy),    1);
        tick();
        d0 = done_seen;
        reset_n = 1'b0;
        #1;
        chk("r_busy0",     32'(busy),      0);
        chk("r_swap0",     32'(swap),      0);
        chk("r_done0",     32'(done),      0);
        chk("r_pending0",  32'(pending),   0);
        chk("r_ready1",    32'(req_ready), 1);
        chk("r_addrA0",    32'(addr_A),    0);
        chk("r_addrB0",    32'(addr_B),    0);
        tick();
        tick();
        reset_n = 1'b1;
        tick(); tick(); tick();
        chk("r_no_done",   32'(done_seen - d0), 0);
        chk("r_still_empty", 32'(pending), 0);
        chk("r_still_idle",  32'(busy),    0);

        req_valid = 1'b1; req_addr_a = 7'h44; req_addr_b = 7'h55;
        tick();
        req_valid = 1'b0;
        tick();
        chk("r_new_swap",  32'(swap),   1);
        chk("r_new_addrA", 32'(addr_A), 'h44);
        chk("r_new_addrB", 32'(addr_B), 'h55);
        guard = 0;
        while (done_seen == d0 && guard < 20) begin
            tick();
            guard++;
        end
        chk("r_new_done_wait", 32'(guard < 20), 1);
`ifdef SWAP_REQ_CTRL_STATS_EN
        chk("r_swap_count", 32'(swap_count), 1);
        chk("r_nop_count",  32'(nop_count),  0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
